// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - UART transmit framer clocked by baud divider edges; define UART_PARITY_EN to add a parity bit
module uart_transmitter #(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       baudIn,
  input  logic [7:0] txData,
  input  logic       txValid,
  output logic       txReady,
  input  logic       parityOdd,
  output logic       txOut,
  output logic       txBusy,
  output logic       txDone
);

  localparam logic [3:0] DATA_LAST = 4'(DATA_BITS);
  localparam logic [1:0] STOP_LAST = 2'(STOP_BITS);

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t     state_q, state_d;
  logic       baud_prev_q;
  logic [7:0] shift_q, shift_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [1:0] stop_cnt_q, stop_cnt_d;
  logic       tx_q, tx_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
`ifdef UART_PARITY_EN
  logic       parity_q, parity_d;
`endif

  logic bit_tick;
  logic last_stop;
  logic accept;

  // Upper txData bits are dropped for narrow frames; parityOdd is idle without parity
  logic unused_inputs;
  assign unused_inputs = ^{parityOdd, txData};

  assign bit_tick  = enable & baudIn & ~baud_prev_q;
  assign last_stop = (stop_cnt_q == STOP_LAST);
  assign txReady   = enable & ((state_q == S_IDLE) |
                               ((state_q == S_STOP) & last_stop & bit_tick));
  assign accept    = txValid & txReady;

  assign txOut  = tx_q;
  assign txBusy = busy_q;
  assign txDone = done_q;

  // Register the FSM and datapath; baud history is tracked even while disabled
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      baud_prev_q <= 1'b0;
      shift_q     <= 8'h00;
      bit_cnt_q   <= 4'd0;
      stop_cnt_q  <= 2'd0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef UART_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      baud_prev_q <= baudIn;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      stop_cnt_q  <= stop_cnt_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef UART_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  // Next-state logic: each bit tick advances the line by one bit period
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    tx_d       = tx_q;
    done_d     = 1'b0;
`ifdef UART_PARITY_EN
    parity_d   = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_SYNC;
          shift_d = txData;
`ifdef UART_PARITY_EN
          parity_d = ^txData[DATA_BITS-1:0] ^ parityOdd;
`endif
        end
      end
      S_SYNC: begin
        if (bit_tick) begin
          state_d = S_START;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (bit_tick) begin
          state_d   = S_DATA;
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = 4'd1;
        end
      end
      S_DATA: begin
        if (bit_tick) begin
          if (bit_cnt_q < DATA_LAST) begin
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else begin
`ifdef UART_PARITY_EN
            state_d    = S_PARITY;
            tx_d       = parity_q;
`else
            state_d    = S_STOP;
            tx_d       = 1'b1;
            stop_cnt_d = 2'd1;
`endif
          end
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        if (bit_tick) begin
          state_d    = S_STOP;
          tx_d       = 1'b1;
          stop_cnt_d = 2'd1;
        end
      end
`endif
      S_STOP: begin
        if (bit_tick) begin
          if (!last_stop) begin
            stop_cnt_d = stop_cnt_q + 2'd1;
          end else begin
            done_d = 1'b1;
            if (accept) begin
              // Back-to-back frame: start bit follows the last stop with no idle gap
              state_d = S_START;
              tx_d    = 1'b0;
              shift_d = txData;
`ifdef UART_PARITY_EN
              parity_d = ^txData[DATA_BITS-1:0] ^ parityOdd;
`endif
            end else begin
              state_d = S_IDLE;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// tb/tb_uart_transmitter.sv - self-checking bench for uart_transmitter against a bit-queue line model
module tb_uart_transmitter;

  localparam int DB = 8;
  localparam int SB = 1;
`ifdef UART_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic       baudIn = 1'b0;
  logic [7:0] txData = 8'h00;
  logic       txValid = 1'b0;
  logic       parityOdd = 1'b0;
  logic       txReady, txOut, txBusy, txDone;

  int n_cmp = 0;
  int n_bad = 0;
  int half = 4;
  int bcnt = 0;

  // Line model: the frame is a queue of bits; every tick shows the next one
  bit m_line = 1'b1;
  bit m_busy = 1'b0;
  bit m_done = 1'b0;
  bit m_bprev = 1'b0;
  bit m_acc = 1'b0;
  bit m_q[$];

  uart_transmitter #(.DATA_BITS(DB), .STOP_BITS(SB)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .baudIn(baudIn),
    .txData(txData), .txValid(txValid), .txReady(txReady), .parityOdd(parityOdd),
    .txOut(txOut), .txBusy(txBusy), .txDone(txDone)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [7:0] d, input logic po);
    bit p;
    p = po;
    m_q.push_back(1'b0);
    for (int i = 0; i < DB; i++) begin
      m_q.push_back(d[i]);
      p = p ^ d[i];
    end
    if (PB == 1) m_q.push_back(p);
    for (int i = 0; i < SB; i++) m_q.push_back(1'b1);
  endtask

  task automatic model_reset();
    m_line = 1'b1; m_busy = 1'b0; m_done = 1'b0; m_bprev = 1'b0; m_acc = 1'b0;
    m_q.delete();
  endtask

  task automatic step_model();
    bit tick, rdy;
    if (!reset_n) begin
      model_reset();
      chk("txReady_reset", txReady, enable);
      return;
    end
    tick = enable && baudIn && !m_bprev;
    m_bprev = baudIn;
    rdy = enable && (!m_busy || (m_q.size() == 0 && tick));
    chk("txReady", txReady, rdy);
    m_acc = txValid && rdy;
    m_done = 1'b0;
    if (tick && m_busy) begin
      if (m_q.size() > 0) begin
        m_line = m_q.pop_front();
      end else begin
        m_done = 1'b1;
        if (m_acc) begin
          push_frame(txData, parityOdd);
          m_line = m_q.pop_front();
        end else begin
          m_busy = 1'b0;
          m_line = 1'b1;
        end
      end
    end else if (m_acc) begin
      push_frame(txData, parityOdd);
      m_busy = 1'b1;
    end
  endtask

  // One clock: advance baud wave, check ready, clock the DUT, check registered outputs
  task automatic cyc();
    bcnt++;
    if (bcnt >= half) begin
      bcnt = 0;
      baudIn = ~baudIn;
    end
    #1;
    step_model();
    @(posedge clock);
    @(negedge clock);
    chk("txOut", txOut, m_line);
    chk("txBusy", txBusy, m_busy);
    chk("txDone", txDone, m_done);
  endtask

  task automatic wait_q(input int n, input int limit);
    int i;
    for (i = 0; i < limit; i++) begin
      if (m_busy && m_q.size() == n) break;
      cyc();
    end
    n_cmp++;
    assert (i < limit) else begin
      n_bad++;
      $error("FAIL wait_q: observed timeout expected queue depth %0d", n);
    end
  endtask

  task automatic wait_idle(input int limit);
    int i;
    for (i = 0; i < limit; i++) begin
      if (!m_busy) break;
      cyc();
    end
    n_cmp++;
    assert (i < limit) else begin
      n_bad++;
      $error("FAIL wait_idle: observed timeout expected idle");
    end
  endtask

  task automatic send(input logic [7:0] b);
    int i;
    txData = b;
    txValid = 1'b1;
    for (i = 0; i < 400; i++) begin
      cyc();
      if (m_acc) break;
    end
    n_cmp++;
    assert (i < 400) else begin
      n_bad++;
      $error("FAIL accept: observed timeout expected accept of %0h", b);
    end
    txValid = 1'b0;
    txData = 8'($urandom);
  endtask

  initial begin
    logic [9:0] pat;
    logic [7:0] b;
    int busy_drops;

    @(negedge clock);

    // Reset held with baud toggling, enable then raised under reset
    reset_n = 1'b0;
    enable = 1'b0;
    for (int i = 0; i < 5; i++) cyc();
    enable = 1'b1;
    cyc();
    reset_n = 1'b1;
    cyc();

    // 0xA5 8N1: explicit line pattern, LSB first
`ifndef UART_PARITY_EN
    pat = 10'b11_0100_1010;
    send(8'hA5);
    for (int k = 0; k < 10; k++) begin
      wait_q(9 - k, 200);
      chk("a5_bit", txOut, pat[k]);
    end
`else
    send(8'hA5);
`endif
    wait_idle(400);

    // Back-to-back 0x00 then 0xFF with txValid held
    busy_drops = 0;
    txData = 8'h00;
    txValid = 1'b1;
    for (int i = 0; i < 200 && !m_acc; i++) cyc();
    txData = 8'hFF;
    for (int i = 0; i < 400; i++) begin
      cyc();
      if (!txBusy) busy_drops++;
      if (m_acc) break;
    end
    txValid = 1'b0;
    n_cmp++;
    assert (busy_drops == 0) else begin
      n_bad++;
      $error("FAIL b2b_busy: observed %0d drops expected 0", busy_drops);
    end
    wait_idle(400);

`ifdef UART_PARITY_EN
    parityOdd = 1'b0;
    send(8'h07);
    wait_q(SB, 200);
    chk("parity_even", txOut, 1'b1);
    wait_idle(400);
    parityOdd = 1'b1;
    send(8'h07);
    wait_q(SB, 200);
    chk("parity_odd", txOut, 1'b0);
    wait_idle(400);
    parityOdd = 1'b0;
`endif

    // Enable pause during data bit 3
    b = 8'($urandom);
    send(b);
    wait_q(DB - 4 + PB + SB, 300);
    cyc();
    enable = 1'b0;
    for (int i = 0; i < 3 * 2 * half; i++) cyc();
    chk("pause_hold", txOut, b[3]);
    enable = 1'b1;
    wait_idle(400);

    // Asynchronous reset during data bit 5, then a clean frame
    b = 8'($urandom);
    send(b);
    wait_q(DB - 6 + PB + SB, 300);
    cyc();
    reset_n = 1'b0;
    #1;
    chk("async_txOut", txOut, 1'b1);
    chk("async_txBusy", txBusy, 1'b0);
    chk("async_txDone", txDone, 1'b0);
    model_reset();
    for (int i = 0; i < 3; i++) cyc();
    reset_n = 1'b1;
    cyc();
    send(8'($urandom));
    wait_idle(400);

    // Random traffic: churning data, bursty valid, enable dropouts, varying baud rate
    for (int i = 0; i < 2500; i++) begin
      if (i % 200 == 0) half = $urandom_range(2, 5);
      txData = 8'($urandom);
      txValid = ($urandom_range(0, 3) != 0);
      enable = ($urandom_range(0, 19) != 0);
      parityOdd = 1'($urandom_range(0, 1));
      cyc();
    end
    txValid = 1'b0;
    enable = 1'b1;
    wait_idle(400);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

Serial transmit framer sitting directly downstream of the baud rate divider in the serial peripheral. It accepts parallel bytes through a valid/ready handshake and shifts them out LSB-first as start, data, optional parity and stop bits on `txOut`. It consumes the divider's square-wave `baudSignalOut`, and one rising edge of that signal marks one bit period. It runs entirely in the divider's clock domain.

## Interface
- `DATA_BITS`, default 8: data bits per frame. Legal range is 5..8; only `txData[DATA_BITS-1:0]` is sent.
- `STOP_BITS`, default 1: number of stop bits. Legal values are 1 or 2.

- `clock`  in  1  system clock. Shared with the baud rate divider.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  block enable. While low, the FSM is frozen and `txReady` is 0.
- `baudIn`  in  1  baud square wave from the divider. Each rising edge is one bit period.
- `txData`  in  8  byte to send.
- `txValid`  in  1  `txData` is valid.
- `txReady`  out  1  block can accept a byte this cycle (combinational).
- `parityOdd`  in  1  0 selects even parity, 1 selects odd. Ignored without `UART_PARITY_EN`.
- `txOut`  out  1  serial line. Idles high.
- `txBusy`  out  1  a frame is in progress (state is not IDLE).
- `txDone`  out  1  one-cycle pulse when the final stop bit ends.

## Operation
- Tick detection:
  - `baudPrev` is registered from `baudIn` every cycle.
  - `bitTick = enable & baudIn & ~baudPrev`.
- Handshake:
  - Accept occurs on `txValid & txReady`.
  - On accept, `txData` is latched into the shift register and parity is computed from the latched bits.
- Ready:
  - `txReady = enable & (state==IDLE | (state==STOP & lastStop & bitTick))`.
- States: IDLE, SYNC, START, DATA, PARITY, STOP. All transitions below except IDLE->SYNC happen only on `bitTick`.
  - IDLE -> SYNC on accept. `txOut` stays 1.
  - SYNC -> START: `txOut`<=0.
  - START -> DATA: `txOut`<=shift[0], shift right, `bitCnt`<=1.
  - DATA, `bitCnt`<DATA_BITS: `txOut`<=next data bit, `bitCnt`++.
  - DATA, `bitCnt`==DATA_BITS: with parity -> PARITY, `txOut`<=parity bit. Without parity -> STOP, `txOut`<=1, `stopCnt`<=1.
  - PARITY -> STOP: `txOut`<=1, `stopCnt`<=1.
  - STOP, `stopCnt`<STOP_BITS: `stopCnt`++.
  - STOP, last stop bit: `txDone`<=1. If an accept occurs in the same cycle, go to START with `txOut`<=0 (back-to-back, no idle gap). Otherwise go to IDLE.
- Parity bit: XOR of the `DATA_BITS` data bits, XOR `parityOdd`.
- Frame length: 1 + DATA_BITS + P + STOP_BITS bit periods, where P=1 with parity and 0 without.
- `enable` low mid-frame: ticks are suppressed and all registers hold, including `txOut`. Transmission resumes at the next rising edge of `baudIn` after `enable` returns.
- `txValid` while not ready: the byte is not consumed and `txData` may change freely.
- `reset_n` low, including mid-frame:
  - State goes to IDLE immediately (asynchronous). The current frame is abandoned and is not resumed.
  - `txOut`=1, `txBusy`=0, `txDone`=0, `baudPrev`=0, counters and shift register cleared.

## Timing
- Reset values: `txOut`=1, `txBusy`=0, `txDone`=0. `txReady` equals `enable`, since state is IDLE.
- All outputs except `txReady` are registered.
- Tick latency: a `bitTick` detected in cycle N changes `txOut` in cycle N+1.
- Accept to start bit: first `bitTick` after accept plus 1 cycle, at most one bit period plus 2 cycles.
- Bit periods: every bit, including the start bit, lasts exactly the interval between consecutive `baudIn` rising edges.
- `txDone`: high for exactly the one cycle following the final stop tick.
- `txBusy`: rises the cycle after accept. Falls together with `txDone` unless a back-to-back accept occurs, in which case it stays high.

## Configuration
- `UART_PARITY_EN` defined: the PARITY state is present and `parityOdd` is honoured.
- `UART_PARITY_EN` undefined: the PARITY state and parity logic are not built, DATA goes directly to STOP, and `parityOdd` is unused.

## Test plan
- Reset: hold `reset_n`=0 for 5 cycles with `baudIn` toggling -> `txOut`=1, `txBusy`=0, `txDone`=0. `txReady`=1 once `enable`=1.
- Single byte, 8N1 (no parity), `txData`=0xA5: line reads 0,1,0,1,0,0,1,0,1,1, one bit per `baudIn` period. Exactly one `txDone` pulse. Returns to IDLE.
- Back-to-back: `txValid` held with 0x00 then 0xFF -> the second start bit begins in the cycle after the first frame's final stop tick. No extra idle bit; `txBusy` never drops.
- Parity (with `UART_PARITY_EN`), 0x07:
  - `parityOdd`=0 -> parity bit 1.
  - `parityOdd`=1 -> parity bit 0.
  - Frame is 11 bit periods.
- Enable pause: deassert `enable` for 3 baud periods during data bit 3 -> `txOut` holds bit 3. The remaining bits follow unchanged after re-enable. `txReady`=0 throughout the pause.
- Mid-frame reset: pulse `reset_n` low during data bit 5 -> `txOut`=1 asynchronously and `txBusy`=0. The next accepted byte produces a clean full frame.
